// File: rtl/map_pkg.sv
// Trellis tables and helpers shared by the max-log-MAP alpha, beta, gamma and LLR units.
// 4-state RSC code, generators (7,5) octal; state s = 2*s1 + s0, gamma indexed by {u,p}.
package map_pkg;

    localparam int NUM_STATES = 4;

    // Transition i of each table sits at element [i] of the packed vector.
    localparam logic [3:0][1:0] FROM_U0 = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [3:0][1:0] TO_U0   = {2'd1, 2'd3, 2'd2, 2'd0};
    localparam logic [3:0]      P_U0    = 4'b1100;

    localparam logic [3:0][1:0] FROM_U1 = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [3:0][1:0] TO_U1   = {2'd3, 2'd1, 2'd0, 2'd2};
    localparam logic [3:0]      P_U1    = 4'b0011;

    function automatic int gamma_idx(input logic u, input logic p);
        return 2 * int'(u) + int'(p);
    endfunction

    function automatic int sat_sym(input int x, input int lim);
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

endpackage

// File: rtl/map_max4.sv
// Combinational signed maximum of four values.
module map_max4 #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] in0,
    input  logic signed [W-1:0] in1,
    input  logic signed [W-1:0] in2,
    input  logic signed [W-1:0] in3,
    output logic signed [W-1:0] max_out
);

    logic signed [W-1:0] m01;
    logic signed [W-1:0] m23;

    assign m01     = (in0 > in1) ? in0 : in1;
    assign m23     = (in2 > in3) ? in2 : in3;
    assign max_out = (m01 > m23) ? m01 : m23;

endmodule

// File: rtl/map_llr_unit.sv
// Max-log-MAP LLR stage: path sums, per-bit maxima, saturated difference and hard decision.
// Three-stage pipeline with a single advance enable; tags the last step of each frame.
module map_llr_unit
    import map_pkg::*;
#(
    parameter int MW        = 10,
    parameter int LW        = 8,
    parameter int BLOCK_LEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*MW-1:0] alpha_in,
    input  logic [4*MW-1:0] beta_in,
    input  logic [4*MW-1:0] gamma_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LW-1:0]   llr_out,
    output logic            hard_bit,
    output logic            out_last,
    output logic            done_llr
);

    localparam int SW      = MW + 2;
    localparam int DW      = MW + 3;
    localparam int CW      = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int LLR_MAX = 2 ** (LW - 1) - 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_LEN - 1);

    function automatic logic signed [SW-1:0] ext(input logic [MW-1:0] x);
        return {{2{x[MW-1]}}, x};
    endfunction

    logic                 en;
    logic                 accept;
    logic [CW-1:0]        count;
    logic signed [SW-1:0] sum0 [NUM_STATES];
    logic signed [SW-1:0] sum1 [NUM_STATES];

    logic                 v1;
    logic                 s1_last;
    logic signed [SW-1:0] s1_sum0 [NUM_STATES];
    logic signed [SW-1:0] s1_sum1 [NUM_STATES];

    logic                 v2;
    logic                 s2_last;
    logic signed [SW-1:0] max0;
    logic signed [SW-1:0] max1;
    logic signed [SW-1:0] s2_max0;
    logic signed [SW-1:0] s2_max1;

    logic signed [DW-1:0] diff;
    int                   sat;
    logic [LW-1:0]        llr_next;
    logic                 hard_next;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    for (genvar i = 0; i < NUM_STATES; i++) begin : g_path
        localparam int F0 = int'(FROM_U0[i]);
        localparam int T0 = int'(TO_U0[i]);
        localparam int G0 = gamma_idx(1'b0, P_U0[i]);
        localparam int F1 = int'(FROM_U1[i]);
        localparam int T1 = int'(TO_U1[i]);
        localparam int G1 = gamma_idx(1'b1, P_U1[i]);

        assign sum0[i] = ext(alpha_in[F0*MW +: MW])
                       + ext(gamma_in[G0*MW +: MW])
                       + ext(beta_in[T0*MW +: MW]);
        assign sum1[i] = ext(alpha_in[F1*MW +: MW])
                       + ext(gamma_in[G1*MW +: MW])
                       + ext(beta_in[T1*MW +: MW]);
    end

    map_max4 #(.W(SW)) u_max0 (
        .in0     (s1_sum0[0]),
        .in1     (s1_sum0[1]),
        .in2     (s1_sum0[2]),
        .in3     (s1_sum0[3]),
        .max_out (max0)
    );

    map_max4 #(.W(SW)) u_max1 (
        .in0     (s1_sum1[0]),
        .in1     (s1_sum1[1]),
        .in2     (s1_sum1[2]),
        .in3     (s1_sum1[3]),
        .max_out (max1)
    );

    always_comb begin
        diff      = {s2_max1[SW-1], s2_max1} - {s2_max0[SW-1], s2_max0};
        sat       = sat_sym(int'(diff), LLR_MAX);
        llr_next  = LW'(sat);
        hard_next = sat > 0;
    end

    // Control and output state: cleared by reset, in-flight data is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            v1        <= 1'b0;
            s1_last   <= 1'b0;
            v2        <= 1'b0;
            s2_last   <= 1'b0;
            out_valid <= 1'b0;
            llr_out   <= '0;
            hard_bit  <= 1'b0;
            out_last  <= 1'b0;
            done_llr  <= 1'b0;
        end else begin
            done_llr <= out_valid && out_ready && out_last;
            if (accept) begin
                count <= (count == LAST_CNT) ? '0 : count + 1'b1;
            end
            if (en) begin
                v1        <= in_valid;
                s1_last   <= in_valid && (count == LAST_CNT);
                v2        <= v1;
                s2_last   <= s1_last;
                out_valid <= v2;
                llr_out   <= llr_next;
                hard_bit  <= hard_next;
                out_last  <= s2_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sum0 <= sum0;
            s1_sum1 <= sum1;
            s2_max0 <= max0;
            s2_max1 <= max1;
        end
    end

endmodule
